// File: rtl/segre_pkg.sv
// Shared types and defaults for the writeback arbiter.
// Entries carry destination, data and instruction id.
package segre_pkg;

  localparam int REG_SIZE      = 5;
  localparam int WORD_SIZE     = 32;
  localparam int HF_PTR        = 4;
  localparam int WB_NUM_PIPES  = 3;
  localparam int WB_NUM_WPORTS = 1;
  localparam int WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [REG_SIZE-1:0]  waddr;
    logic [WORD_SIZE-1:0] data;
    logic [HF_PTR-1:0]    id;
  } wb_entry_t;

endpackage

// File: rtl/segre_wb_arbiter_if.sv
// Producer-side requests and register-file write ports.
// The arbiter sits on the slave modport.
interface segre_wb_arbiter_if
  import segre_pkg::*;
#(
  parameter int NUM_PIPES  = WB_NUM_PIPES,
  parameter int NUM_WPORTS = WB_NUM_WPORTS
);

  logic [NUM_PIPES-1:0]                 pipe_valid_i;
  logic [NUM_PIPES-1:0][REG_SIZE-1:0]   pipe_waddr_i;
  logic [NUM_PIPES-1:0][WORD_SIZE-1:0]  pipe_data_i;
  logic [NUM_PIPES-1:0][HF_PTR-1:0]     pipe_id_i;
  logic [NUM_PIPES-1:0]                 pipe_stall_o;
  logic [NUM_WPORTS-1:0]                wp_we_o;
  logic [NUM_WPORTS-1:0][REG_SIZE-1:0]  wp_waddr_o;
  logic [NUM_WPORTS-1:0][WORD_SIZE-1:0] wp_data_o;
  logic [NUM_WPORTS-1:0][HF_PTR-1:0]    wp_id_o;

  modport master (
    output pipe_valid_i, pipe_waddr_i,
    output pipe_data_i, pipe_id_i,
    input  pipe_stall_o,
    input  wp_we_o, wp_waddr_o,
    input  wp_data_o, wp_id_o
  );

  modport slave (
    input  pipe_valid_i, pipe_waddr_i,
    input  pipe_data_i, pipe_id_i,
    output pipe_stall_o,
    output wp_we_o, wp_waddr_o,
    output wp_data_o, wp_id_o
  );

endinterface

// File: rtl/segre_wb_fifo.sv
// Per-pipe writeback queue with wrap-bit pointers.
// Whole entry array and live mask are exported.
module segre_wb_fifo
  import segre_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rsn_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  wb_entry_t                  entry_i,
  output wb_entry_t                  head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output wb_entry_t [DEPTH-1:0]      mem_o,
  output logic [DEPTH-1:0]           live_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] head_q, tail_q;
  wb_entry_t [DEPTH-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q[AW-1:0]] <= entry_i;
        tail_q <= tail_q + 1'b1;
      end
      if (pop_i) head_q <= head_q + 1'b1;
    end
  end

  assign count_o = tail_q - head_q;
  assign empty_o = head_q == tail_q;
  assign full_o  = (head_q[AW] != tail_q[AW]) &&
                   (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign head_o  = mem_q[head_q[AW-1:0]];
  assign mem_o   = mem_q;

  // slot is live when its distance from head is below count
  always_comb begin
    logic [AW-1:0] off;
    off    = '0;
    live_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_q[AW-1:0];
      live_o[i] = {1'b0, off} < count_o;
    end
  end

endmodule

// File: rtl/segre_wb_arbiter.sv
// Round-robin writeback arbiter: per-pipe queues
// feeding NUM_WPORTS registered register-file ports.
module segre_wb_arbiter
  import segre_pkg::*;
#(
  parameter int NUM_PIPES  = WB_NUM_PIPES,
  parameter int NUM_WPORTS = WB_NUM_WPORTS,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rsn_i,
  input  logic                      flush_i,
  segre_wb_arbiter_if.slave         bus,
  output logic [(1<<REG_SIZE)-1:0]  pending_o,
  output logic                      overflow_o
);

  localparam int PW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_PIPES-1:0] push, pop, full, empty;
  logic [NUM_PIPES-1:0][CW-1:0] count;
  wb_entry_t [NUM_PIPES-1:0] head, in_e;
  wb_entry_t [NUM_PIPES-1:0][FIFO_DEPTH-1:0] mem;
  logic [NUM_PIPES-1:0][FIFO_DEPTH-1:0] live;

  logic [PW-1:0] rr_q, rr_d;
  logic [NUM_WPORTS-1:0] gnt_we, wp_we;
  wb_entry_t [NUM_WPORTS-1:0] gnt_e, wp_e;

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
    assign in_e[p] = '{waddr: bus.pipe_waddr_i[p],
                       data:  bus.pipe_data_i[p],
                       id:    bus.pipe_id_i[p]};
    assign push[p] = bus.pipe_valid_i[p] && !full[p] &&
                     (|bus.pipe_waddr_i[p]) && !flush_i;
    assign bus.pipe_stall_o[p] = count[p] == CW'(FIFO_DEPTH);

    segre_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .flush_i (flush_i),
      .push_i  (push[p]),
      .pop_i   (pop[p]),
      .entry_i (in_e[p]),
      .head_o  (head[p]),
      .full_o  (full[p]),
      .empty_o (empty[p]),
      .count_o (count[p]),
      .mem_o   (mem[p]),
      .live_o  (live[p])
    );
  end

  // a head whose waddr is already granted this cycle waits
  always_comb begin
    int   p, n;
    logic clash;
    pop    = '0;
    gnt_we = '0;
    gnt_e  = '0;
    rr_d   = rr_q;
    p      = 0;
    n      = 0;
    clash  = 1'b0;
    for (int j = 0; j < NUM_PIPES; j++) begin
      p = int'(rr_q) + j;
      if (p >= NUM_PIPES) p = p - NUM_PIPES;
      clash = 1'b0;
      for (int k = 0; k < NUM_WPORTS; k++)
        if (gnt_we[k] && gnt_e[k].waddr == head[p].waddr)
          clash = 1'b1;
      if (!empty[p] && n < NUM_WPORTS && !clash) begin
        pop[p]    = 1'b1;
        gnt_we[n] = 1'b1;
        gnt_e[n]  = head[p];
        n         = n + 1;
        rr_d      = (p == NUM_PIPES - 1) ? '0 : PW'(p + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      rr_q       <= '0;
      wp_we      <= '0;
      wp_e       <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      wp_we <= '0;
      wp_e  <= '0;
    end else begin
      rr_q  <= rr_d;
      wp_we <= gnt_we;
      wp_e  <= gnt_e;
      if (|(bus.pipe_valid_i & full)) overflow_o <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_WPORTS; k++) begin : g_port
    assign bus.wp_we_o[k]    = wp_we[k];
    assign bus.wp_waddr_o[k] = wp_e[k].waddr;
    assign bus.wp_data_o[k]  = wp_e[k].data;
    assign bus.wp_id_o[k]    = wp_e[k].id;
  end

  always_comb begin
    pending_o = '0;
    for (int p = 0; p < NUM_PIPES; p++)
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (live[p][i]) pending_o[mem[p][i].waddr] = 1'b1;
    for (int k = 0; k < NUM_WPORTS; k++)
      if (wp_we[k]) pending_o[wp_e[k].waddr] = 1'b1;
  end

  always @(posedge clk_i) begin
    if (rsn_i)
      for (int a = 0; a < NUM_WPORTS; a++)
        for (int b = a + 1; b < NUM_WPORTS; b++)
          assert (!(wp_we[a] && wp_we[b] &&
                    wp_e[a].waddr == wp_e[b].waddr))
          else $fatal(1, "wp_waddr_o collision");
  end

endmodule
